// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rob_pkg
//  Description : Shared types, default sizing and the commit prefix-mask helper
//                for the multi-port reorder buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rob_pkg;

    localparam int c_DEPTH      = 32;
    localparam int c_XLEN       = 32;
    localparam int c_AREG_W     = 5;
    localparam int c_NUM_WB     = 3;
    localparam int c_COMMIT_W   = 2;
    localparam int c_MAX_COMMIT = 64;

    // Entry layout at the default widths; rob_mp re-declares it at its own widths.
    typedef struct packed {
        logic                valid;
        logic                done;
        logic                exc;
        logic [c_AREG_W-1:0] prd;
        logic [c_XLEN-1:0]   pc;
        logic [c_XLEN-1:0]   inst;
        logic [c_XLEN-1:0]   value;
    } rob_entry_t;

    // Bit k is set only while every eligibility bit 0..k is set.
    function automatic logic [c_MAX_COMMIT-1:0] prefix_mask(input logic [c_MAX_COMMIT-1:0] elig);
        logic                    run;
        logic [c_MAX_COMMIT-1:0] mask;
        run  = 1'b1;
        mask = '0;
        for (int i = 0; i < c_MAX_COMMIT; i++) begin
            run     = run & elig[i];
            mask[i] = run;
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_commit_sel.sv
`default_nettype none
// ============================================================================
//  Module      : rob_commit_sel
//  Description : In-order commit scan over the COMMIT_W entries starting at
//                head; yields commit mask, commit count and exception-at-head.
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_commit_sel
    import rob_pkg::*;
#(
    parameter int COMMIT_W = c_COMMIT_W,
    parameter int CNT_W    = 6
) (
    input  logic [COMMIT_W-1:0] win_valid_i,
    input  logic [COMMIT_W-1:0] win_done_i,
    input  logic [COMMIT_W-1:0] win_exc_i,
    input  logic [CNT_W-1:0]    count_i,
    output logic [COMMIT_W-1:0] commit_mask_o,
    output logic [CNT_W-1:0]    commit_cnt_o,
    output logic                exc_head_o
);

    logic [c_MAX_COMMIT-1:0] w_elig_ext;

    always_comb begin
        w_elig_ext = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            w_elig_ext[k] = win_valid_i[k] & win_done_i[k] & ~win_exc_i[k]
                          & (CNT_W'(k) < count_i);
        end
        commit_mask_o = COMMIT_W'(prefix_mask(w_elig_ext));
        commit_cnt_o  = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            commit_cnt_o = commit_cnt_o + CNT_W'(commit_mask_o[k]);
        end
    end

    assign exc_head_o = win_valid_i[0] & win_done_i[0] & win_exc_i[0] & (count_i != '0);

endmodule
`default_nettype wire

// File: rtl/rob_mp.sv
`default_nettype none
// ============================================================================
//  Module      : rob_mp
//  Description : Parametrised reorder buffer with NUM_WB writeback ports,
//                COMMIT_W-wide in-order commit, precise exception and flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_mp
    import rob_pkg::*;
#(
    parameter int DEPTH    = c_DEPTH,
    parameter int XLEN     = c_XLEN,
    parameter int AREG_W   = c_AREG_W,
    parameter int NUM_WB   = c_NUM_WB,
    parameter int COMMIT_W = c_COMMIT_W,
    parameter int IDX_W    = $clog2(DEPTH)
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       flush_i,
    input  logic                       alloc_valid_i,
    output logic                       alloc_ready_o,
    input  logic [AREG_W-1:0]          alloc_prd_addr_i,
    input  logic [XLEN-1:0]            alloc_pc_i,
    input  logic [XLEN-1:0]            alloc_inst_i,
    output logic [IDX_W-1:0]           alloc_rob_idx_o,
    input  logic [NUM_WB-1:0]          wb_valid_i,
    input  logic [NUM_WB*IDX_W-1:0]    wb_rob_idx_i,
    input  logic [NUM_WB*XLEN-1:0]     wb_value_i,
    input  logic [NUM_WB-1:0]          wb_exc_i,
    output logic [COMMIT_W-1:0]        commit_valid_o,
    output logic [COMMIT_W*XLEN-1:0]   commit_inst_o,
    output logic [COMMIT_W*XLEN-1:0]   commit_pc_o,
    output logic [COMMIT_W*AREG_W-1:0] commit_prd_addr_o,
    output logic [COMMIT_W*XLEN-1:0]   commit_prd_value_o,
    output logic                       exc_valid_o,
    output logic [XLEN-1:0]            exc_pc_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [IDX_W:0]             count_o
);

    localparam int             c_PTR_W = IDX_W + 1;
    localparam logic [IDX_W:0] c_FULL  = c_PTR_W'(DEPTH);

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              exc;
        logic [AREG_W-1:0] prd;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   inst;
        logic [XLEN-1:0]   value;
    } entry_t;

    entry_t            r_entries [DEPTH];
    logic [IDX_W:0]    r_head;
    logic [IDX_W:0]    r_tail;
    logic [IDX_W:0]    r_count;

    logic              w_full;
    logic              w_alloc_fire;
    logic [IDX_W-1:0]  w_win_idx [COMMIT_W];
    logic [COMMIT_W-1:0] w_win_valid;
    logic [COMMIT_W-1:0] w_win_done;
    logic [COMMIT_W-1:0] w_win_exc;
    logic [COMMIT_W-1:0] w_commit_mask;
    logic [IDX_W:0]    w_commit_cnt;
    logic              w_exc_head;
    logic [DEPTH-1:0]  w_wb_hit;
    logic [DEPTH-1:0]  w_wb_exc;
    logic [XLEN-1:0]   w_wb_value [DEPTH];
    logic [DEPTH-1:0]  w_commit_clr;

    assign w_full          = (r_count == c_FULL);
    assign w_alloc_fire    = alloc_valid_i & ~w_full;
    assign alloc_ready_o   = ~w_full;
    assign alloc_rob_idx_o = r_tail[IDX_W-1:0];
    assign full_o          = w_full;
    assign empty_o         = (r_count == '0);
    assign count_o         = r_count;

    for (genvar k = 0; k < COMMIT_W; k++) begin : g_win
        assign w_win_idx[k]   = r_head[IDX_W-1:0] + IDX_W'(k);
        assign w_win_valid[k] = r_entries[w_win_idx[k]].valid;
        assign w_win_done[k]  = r_entries[w_win_idx[k]].done;
        assign w_win_exc[k]   = r_entries[w_win_idx[k]].exc;

        // Data buses read zero on idle slots so downstream never sees stale entries.
        assign commit_valid_o[k]                         = w_commit_mask[k] & ~flush_i;
        assign commit_inst_o[k*XLEN +: XLEN]             = commit_valid_o[k] ? r_entries[w_win_idx[k]].inst  : '0;
        assign commit_pc_o[k*XLEN +: XLEN]               = commit_valid_o[k] ? r_entries[w_win_idx[k]].pc    : '0;
        assign commit_prd_addr_o[k*AREG_W +: AREG_W]     = commit_valid_o[k] ? r_entries[w_win_idx[k]].prd   : '0;
        assign commit_prd_value_o[k*XLEN +: XLEN]        = commit_valid_o[k] ? r_entries[w_win_idx[k]].value : '0;
    end

    rob_commit_sel #(
        .COMMIT_W (COMMIT_W),
        .CNT_W    (c_PTR_W)
    ) u_commit_sel (
        .win_valid_i   (w_win_valid),
        .win_done_i    (w_win_done),
        .win_exc_i     (w_win_exc),
        .count_i       (r_count),
        .commit_mask_o (w_commit_mask),
        .commit_cnt_o  (w_commit_cnt),
        .exc_head_o    (w_exc_head)
    );

    assign exc_valid_o = w_exc_head & ~flush_i;
    assign exc_pc_o    = exc_valid_o ? r_entries[r_head[IDX_W-1:0]].pc : '0;

    // Ports scanned high to low so the lowest-numbered port wins on a collision.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wb_hit[i]   = 1'b0;
            w_wb_exc[i]   = 1'b0;
            w_wb_value[i] = '0;
            for (int p = NUM_WB - 1; p >= 0; p--) begin
                if (wb_valid_i[p] && (wb_rob_idx_i[p*IDX_W +: IDX_W] == IDX_W'(i))) begin
                    w_wb_hit[i]   = 1'b1;
                    w_wb_exc[i]   = wb_exc_i[p];
                    w_wb_value[i] = wb_value_i[p*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        w_commit_clr = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (w_commit_mask[k]) begin
                w_commit_clr[w_win_idx[k]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni || flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_commit_clr[i]) begin
                    r_entries[i].valid <= 1'b0;
                    r_entries[i].done  <= 1'b0;
                    r_entries[i].exc   <= 1'b0;
                end else if (w_wb_hit[i] && r_entries[i].valid) begin
                    r_entries[i].done  <= 1'b1;
                    r_entries[i].exc   <= w_wb_exc[i];
                    r_entries[i].value <= w_wb_value[i];
                end
            end
            if (w_alloc_fire) begin
                r_entries[r_tail[IDX_W-1:0]].valid <= 1'b1;
                r_entries[r_tail[IDX_W-1:0]].done  <= 1'b0;
                r_entries[r_tail[IDX_W-1:0]].exc   <= 1'b0;
                r_entries[r_tail[IDX_W-1:0]].prd   <= alloc_prd_addr_i;
                r_entries[r_tail[IDX_W-1:0]].pc    <= alloc_pc_i;
                r_entries[r_tail[IDX_W-1:0]].inst  <= alloc_inst_i;
            end
            r_tail  <= r_tail + c_PTR_W'(w_alloc_fire);
            r_head  <= r_head + w_commit_cnt;
            r_count <= r_count + c_PTR_W'(w_alloc_fire) - w_commit_cnt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_mp
//  Description : Scoreboard bench for rob_mp (DEPTH=8, 3 WB ports, 2 commits).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_mp;

    localparam int c_DEPTH = 8;
    localparam int c_IDX_W = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  prd;
        logic [31:0] val;
        logic [31:0] inst;
    } exp_t;

    logic        clk;
    logic        reset_ni;
    logic        flush_i;
    logic        alloc_valid_i;
    logic        alloc_ready_o;
    logic [4:0]  alloc_prd_addr_i;
    logic [31:0] alloc_pc_i;
    logic [31:0] alloc_inst_i;
    logic [2:0]  alloc_rob_idx_o;
    logic [2:0]  wb_valid_i;
    logic [8:0]  wb_rob_idx_i;
    logic [95:0] wb_value_i;
    logic [2:0]  wb_exc_i;
    logic [1:0]  commit_valid_o;
    logic [63:0] commit_inst_o;
    logic [63:0] commit_pc_o;
    logic [9:0]  commit_prd_addr_o;
    logic [63:0] commit_prd_value_o;
    logic        exc_valid_o;
    logic [31:0] exc_pc_o;
    logic        empty_o;
    logic        full_o;
    logic [3:0]  count_o;

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    exp_t sb[$];

    rob_mp #(
        .DEPTH    (c_DEPTH),
        .XLEN     (32),
        .AREG_W   (5),
        .NUM_WB   (3),
        .COMMIT_W (2)
    ) dut (
        .clk_i              (clk),
        .reset_ni           (reset_ni),
        .flush_i            (flush_i),
        .alloc_valid_i      (alloc_valid_i),
        .alloc_ready_o      (alloc_ready_o),
        .alloc_prd_addr_i   (alloc_prd_addr_i),
        .alloc_pc_i         (alloc_pc_i),
        .alloc_inst_i       (alloc_inst_i),
        .alloc_rob_idx_o    (alloc_rob_idx_o),
        .wb_valid_i         (wb_valid_i),
        .wb_rob_idx_i       (wb_rob_idx_i),
        .wb_value_i         (wb_value_i),
        .wb_exc_i           (wb_exc_i),
        .commit_valid_o     (commit_valid_o),
        .commit_inst_o      (commit_inst_o),
        .commit_pc_o        (commit_pc_o),
        .commit_prd_addr_o  (commit_prd_addr_o),
        .commit_prd_value_o (commit_prd_value_o),
        .exc_valid_o        (exc_valid_o),
        .exc_pc_o           (exc_pc_o),
        .empty_o            (empty_o),
        .full_o             (full_o),
        .count_o            (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input int prd, input int pc, input int exp_idx);
        alloc_valid_i    = 1'b1;
        alloc_prd_addr_i = 5'(prd);
        alloc_pc_i       = 32'(pc);
        alloc_inst_i     = inst_of(32'(pc));
        #1;
        chk("alloc_idx", 64'(alloc_rob_idx_o), 64'(exp_idx));
        cyc();
        alloc_valid_i = 1'b0;
    endtask

    task automatic wb(input int p, input int idx, input int val, input logic exc);
        wb_valid_i[p]             = 1'b1;
        wb_rob_idx_i[p*3 +: 3]    = 3'(idx);
        wb_value_i[p*32 +: 32]    = 32'(val);
        wb_exc_i[p]               = exc;
    endtask

    task automatic wb_go();
        cyc();
        wb_valid_i = '0;
        wb_exc_i   = '0;
    endtask

    task automatic push(input int pc, input int prd, input int val);
        exp_t e;
        e.pc   = 32'(pc);
        e.prd  = 5'(prd);
        e.val  = 32'(val);
        e.inst = inst_of(32'(pc));
        sb.push_back(e);
    endtask

    // Monitor: every committed slot must match the next scoreboard entry.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                if (commit_valid_o[k]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL commit_unexpected: got slot %0d pc %0h expected no commit",
                                 k, commit_pc_o[k*32 +: 32]);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("commit_pc",    64'(commit_pc_o[k*32 +: 32]),        64'(e.pc));
                        chk("commit_prd",   64'(commit_prd_addr_o[k*5 +: 5]),    64'(e.prd));
                        chk("commit_value", 64'(commit_prd_value_o[k*32 +: 32]), 64'(e.val));
                        chk("commit_inst",  64'(commit_inst_o[k*32 +: 32]),      64'(e.inst));
                    end
                end
            end
        end
    end

    initial begin
        reset_ni         = 1'b0;
        flush_i          = 1'b0;
        alloc_valid_i    = 1'b0;
        alloc_prd_addr_i = '0;
        alloc_pc_i       = '0;
        alloc_inst_i     = '0;
        wb_valid_i       = '0;
        wb_rob_idx_i     = '0;
        wb_value_i       = '0;
        wb_exc_i         = '0;
        cyc();
        cyc();

        chk("rst_count",    64'(count_o),         64'd0);
        chk("rst_empty",    64'(empty_o),         64'd1);
        chk("rst_full",     64'(full_o),          64'd0);
        chk("rst_ready",    64'(alloc_ready_o),   64'd1);
        chk("rst_idx",      64'(alloc_rob_idx_o), 64'd0);
        chk("rst_commit",   64'(commit_valid_o),  64'd0);
        chk("rst_exc",      64'(exc_valid_o),     64'd0);
        chk("rst_exc_pc",   64'(exc_pc_o),        64'd0);
        chk("rst_cpc",      commit_pc_o,          64'd0);
        chk("rst_cval",     commit_prd_value_o,   64'd0);
        reset_ni = 1'b1;
        mon_en   = 1'b1;

        // Five allocations
        alloc(5, 'h0, 0);
        alloc(3, 'h4, 1);
        alloc(6, 'h8, 2);
        alloc(4, 'hC, 3);
        alloc(1, 'h10, 4);
        chk("t1_count",  64'(count_o),        64'd5);
        chk("t1_empty",  64'(empty_o),        64'd0);
        chk("t1_commit", 64'(commit_valid_o), 64'd0);

        // Out-of-order writeback: nothing commits until head is done
        wb(0, 1, 5, 1'b0);
        wb(1, 3, 4, 1'b0);
        wb_go();
        chk("t2_no_commit", 64'(commit_valid_o), 64'd0);
        push('h0, 5, 'h7);
        push('h4, 3, 'h5);
        wb(0, 0, 'h7, 1'b0);
        wb_go();
        chk("t2_commit2", 64'(commit_valid_o), 64'd3);
        cyc();
        chk("t2_count", 64'(count_o), 64'd3);

        // Port 0 and port 2 collide on idx 2: port 0 value wins
        push('h8, 6, 'hA);
        push('hC, 4, 'h4);
        wb(0, 2, 'hA, 1'b0);
        wb(2, 2, 'hB, 1'b0);
        wb_go();
        chk("t4_commit2", 64'(commit_valid_o), 64'd3);
        cyc();
        chk("t4_count", 64'(count_o), 64'd1);
        push('h10, 1, 'h44);
        wb(2, 4, 'h44, 1'b0);
        wb_go();
        chk("t4_commit1", 64'(commit_valid_o), 64'd1);
        cyc();
        chk("t4_empty", 64'(empty_o), 64'd1);

        // Precise exception on entry 1, then flush
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        chk("t5_flush_idx", 64'(alloc_rob_idx_o), 64'd0);
        alloc(2, 'h0, 0);
        alloc(7, 'h4, 1);
        push('h0, 2, 'h11);
        wb(1, 1, 'h99, 1'b1);
        wb(0, 0, 'h11, 1'b0);
        wb_go();
        chk("t5_slot0_only", 64'(commit_valid_o), 64'd1);
        chk("t5_exc_early",  64'(exc_valid_o),    64'd0);
        cyc();
        chk("t5_exc_valid",  64'(exc_valid_o),    64'd1);
        chk("t5_exc_pc",     64'(exc_pc_o),       64'h4);
        chk("t5_exc_nocmt",  64'(commit_valid_o), 64'd0);
        cyc();
        chk("t5_exc_hold",   64'(exc_valid_o),    64'd1);
        flush_i = 1'b1;
        #1;
        chk("t5_flush_gate", 64'(exc_valid_o),    64'd0);
        cyc();
        flush_i = 1'b0;
        chk("t5_empty", 64'(empty_o), 64'd1);
        chk("t5_count", 64'(count_o), 64'd0);

        // Fill to DEPTH, refuse an extra request, drain, then wrap
        for (int i = 0; i < c_DEPTH; i++) alloc(i, 'h100 + 4*i, i);
        chk("t3_full",  64'(full_o),        64'd1);
        chk("t3_ready", 64'(alloc_ready_o), 64'd0);
        chk("t3_count", 64'(count_o),       64'd8);
        alloc_valid_i    = 1'b1;
        alloc_pc_i       = 32'hDEAD;
        alloc_inst_i     = inst_of(32'hDEAD);
        alloc_prd_addr_i = 5'd31;
        cyc();
        alloc_valid_i = 1'b0;
        chk("t3_extra_count", 64'(count_o),         64'd8);
        chk("t3_extra_idx",   64'(alloc_rob_idx_o), 64'd0);
        for (int i = 0; i < c_DEPTH; i++) begin
            push('h100 + 4*i, i, 'h200 + i);
            wb(i % 3, i, 'h200 + i, 1'b0);
            wb_go();
        end
        cyc();
        cyc();
        chk("t3_drained", 64'(count_o), 64'd0);
        alloc(1, 'h300, 0);
        alloc(2, 'h304, 1);
        alloc(3, 'h308, 2);
        chk("t3_wrap_count", 64'(count_o), 64'd3);

        // Reset with live entries and a concurrent allocation
        alloc(4, 'h30C, 3);
        reset_ni         = 1'b0;
        alloc_valid_i    = 1'b1;
        alloc_pc_i       = 32'h400;
        alloc_inst_i     = inst_of(32'h400);
        alloc_prd_addr_i = 5'd9;
        cyc();
        reset_ni      = 1'b1;
        alloc_valid_i = 1'b0;
        chk("t6_count", 64'(count_o),         64'd0);
        chk("t6_empty", 64'(empty_o),         64'd1);
        chk("t6_idx",   64'(alloc_rob_idx_o), 64'd0);

        cyc();
        cyc();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rob_mp.md
Name: rob_mp

Overview:
- Parametrised successor to the single-issue reorder buffer.
- Generic depth, data width and NUM_WB writeback ports; in-order commit of up to COMMIT_W entries per cycle.
- Adds precise-exception capture and a global flush.
- Sits between rename/dispatch (allocate), the execution units (writeback) and the architectural register file (commit).

Parameters:
- DEPTH, 32, number of entries; power of two, at least 4
- XLEN, 32, data, PC and instruction width
- AREG_W, 5, destination register address width
- NUM_WB, 3, writeback ports (port 0 = ALU, 1 = LSU, 2 = MUL by convention)
- COMMIT_W, 2, maximum commits per cycle; 1 to DEPTH
- IDX_W, $clog2(DEPTH), derived; not overridden

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  synchronous reset, active-low
- flush_i  in  1  discard all entries
- alloc_valid_i  in  1  allocation request
- alloc_ready_o  out  1  ROB can accept an allocation (not full)
- alloc_prd_addr_i  in  AREG_W  destination register
- alloc_pc_i  in  XLEN  PC
- alloc_inst_i  in  XLEN  instruction word
- alloc_rob_idx_o  out  IDX_W  index granted (current tail)
- wb_valid_i  in  NUM_WB  per-port writeback strobe
- wb_rob_idx_i  in  NUM_WB*IDX_W  per-port target index, packed, port 0 in LSBs
- wb_value_i  in  NUM_WB*XLEN  per-port result
- wb_exc_i  in  NUM_WB  per-port exception flag
- commit_valid_o  out  COMMIT_W  slot k commits this cycle
- commit_inst_o  out  COMMIT_W*XLEN  committed instruction per slot
- commit_pc_o  out  COMMIT_W*XLEN  committed PC per slot
- commit_prd_addr_o  out  COMMIT_W*AREG_W  committed destination per slot
- commit_prd_value_o  out  COMMIT_W*XLEN  committed value per slot
- exc_valid_o  out  1  head entry carries an exception
- exc_pc_o  out  XLEN  PC of the excepting entry
- empty_o  out  1  count == 0
- full_o  out  1  count == DEPTH
- count_o  out  IDX_W+1  occupied entries

Behaviour:
- Reset (reset_ni low at a posedge): all entry valid/done/exc bits cleared; head = tail = 0; count = 0.
  - Resulting outputs: empty_o=1, full_o=0, alloc_ready_o=1, count_o=0, alloc_rob_idx_o=0, commit_valid_o=0, exc_valid_o=0, data outputs 0.
  - Reset overrides flush, allocate and writeback in the same cycle.
- Pointers: head and tail are IDX_W+1 bits with a wrap bit. Entry index = low IDX_W bits. Wrap from DEPTH-1 to 0 is natural overflow.
- Allocate: fires when alloc_valid_i && alloc_ready_o.
  - Entry[tail] is written with valid=1, done=0, exc=0, plus pc, inst and prd; tail increments at the edge.
  - alloc_rob_idx_o = tail[IDX_W-1:0], combinational, valid in the request cycle.
  - alloc_ready_o = !full_o. There is no same-cycle commit bypass; a full ROB refuses allocation even if a commit occurs that cycle.
- Writeback: for each port p with wb_valid_i[p]:
  - If entry[idx] is valid, set done=1, value=wb_value_i[p], exc=wb_exc_i[p].
  - A writeback to an invalid entry is silently ignored, including an entry being allocated in the same cycle.
  - Two ports targeting the same index in one cycle: the lowest port number wins.
  - State updates at the edge; the entry becomes commit-eligible the following cycle (1-cycle writeback-to-commit latency minimum).
- Commit (combinational from registered state):
  - Slot k (k = 0..COMMIT_W-1) is valid iff entries head..head+k are all valid, done and exc=0, and k < count.
  - Slots fill strictly in order; the first non-eligible entry stops all later slots.
  - At the edge, head advances by the number of valid slots and those entries are cleared.
- Exception:
  - If the head entry is valid, done and exc=1, then exc_valid_o=1 and exc_pc_o = that entry's PC. The excepting entry does not commit.
  - Older entries ahead of it commit normally in earlier slots; exc_valid_o is asserted only once the excepting entry is at head.
  - The ROB holds this state until flush_i.
- Flush:
  - flush_i gates commit_valid_o and exc_valid_o to 0 in the same cycle.
  - At the edge: all valid bits cleared, head = tail = 0, count = 0. Allocation and writeback in the flush cycle are discarded.
- Count: count_next = count + alloc_fire - num_commits. Simultaneous allocate and commit is legal.
- Illegal use (do not handle): alloc_valid_i while full (ignored, no state change).

Decomposition:
- Package rob_pkg:
  - rob_entry_t struct: valid, done, exc, prd, pc, inst, value.
  - Default parameter constants.
  - Function computing the commit-slot prefix mask.
- One sub-module, rob_commit_sel: combinational prefix scan over COMMIT_W entries from head. Produces the commit mask, commit count and the exception-at-head flag.
- Entry array, pointers and writeback priority logic live in rob_mp.

Test Plan:
- Reset, then allocate 5 entries (pc 0x0..0x10, prd 5,3,6,4,1) -> alloc_rob_idx_o 0..4, count_o=5, empty_o=0, no commits.
- Writeback idx 1 (val 5, port 0) and idx 3 (val 4, port 1) only -> no commit (head 0 not done). Then writeback idx 0 (val 0x7) -> next cycle commit_valid_o=2'b11 with values 0x7 and 5 (pc 0x0, 0x4); count_o=3.
- Allocate DEPTH entries -> full_o=1, alloc_ready_o=0. An extra request leaves tail unchanged. Commit all and allocate 3 more -> indices wrap to 0,1,2.
- Ports 0 and 2 write idx 2 in the same cycle with values 0xA/0xB -> the committed value is 0xA.
- Entry 1 written with wb_exc_i=1 and entry 0 done -> cycle N: slot 0 commits entry 0. Cycle N+1: exc_valid_o=1, exc_pc_o=0x4, commit_valid_o=0. flush_i -> next cycle empty_o=1, count_o=0.
- Assert reset_ni=0 with 4 entries live and allocate asserted -> next cycle count_o=0, empty_o=1, alloc_rob_idx_o=0.
